stream_conv2d: RTL and testbench

STREAM_CONV2D -- requirements
Module: stream_conv2d

---
 rtl/stream_conv2d.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_stream_conv2d.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_conv2d.sv
// stream_conv2d -- streaming K x K 2D convolution over a raster-order pixel
// stream with zero padding at the image borders.
//
// Pixels enter in raster order. K-1 line buffers feed a K x K window register;
// each window whose centre lies inside the image produces one output pixel.
// After the last input pixel of a frame the block pushes R*IMG_WIDTH+R zero
// pixels internally (FLUSH) to finish the bottom rows. Zero padding comes from
// the output position, so stale line-buffer contents never reach the output.
// The line buffers and window are not reset.
//
// Output pixel: sat(round(sum >>> SHIFT)). sum is the full-precision signed
// sum of pixel*coefficient. Rounding adds 2^(SHIFT-1) before the shift.
// sat clamps to 0 .. 2^W-1.
//
// Optional build macro:
//   STREAM_CONV2D_ABS_EN  use |sum| instead of sum before the shift, which
//                         suits edge detectors.
//   Without the macro, negative sums clamp to 0.
//
// Ports:
//   clk, rst_n         clock; synchronous active-low reset
//   x_valid/x_ready    input handshake; x_data is the W-bit unsigned pixel
//   y_valid/y_ready    output handshake; y_data is registered and holds
//                      stable while stalled
//   kernel             K*K signed W_COEF-bit coefficients, row-major,
//                      entry [0][0] in the LSBs. Latched on a frame's first
//                      accepted pixel.
//   frame_done         high in the cycle the last output pixel of a frame
//                      is accepted

module stream_conv2d #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int K          = 3,
  parameter int W          = 8,
  parameter int W_COEF     = 8,
  parameter int SHIFT      = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  x_valid,
  output logic                  x_ready,
  input  logic [W-1:0]          x_data,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [W-1:0]          y_data,
  input  logic [K*K*W_COEF-1:0] kernel,
  output logic                  frame_done
);

  localparam int R      = (K - 1) / 2;
  localparam int NPIX   = IMG_WIDTH * IMG_HEIGHT;
  // Pushes needed before the window centre reaches pixel (0,0).
  localparam int NLEAD  = R * IMG_WIDTH + R;
  localparam int NPUSH  = NPIX + NLEAD;
  localparam int CNT_W  = $clog2(NPUSH + 1);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = $clog2(IMG_HEIGHT);
  localparam int PROD_W = W + W_COEF + 1;
  localparam int SUM_W  = W + W_COEF + $clog2(K * K) + 1;

  localparam logic signed [SUM_W-1:0] PIX_MAX = {{(SUM_W - W){1'b0}}, {W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Push position: linear index of the next pixel shifted into the window,
  // and its column (the line-buffer address).
  logic [CNT_W-1:0] push_cnt;
  logic [COL_W-1:0] in_col;
  // Image position of the next output pixel.
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;

  logic             adv;
  logic             x_acc;
  logic             flush_push;
  logic             push;
  logic             out_prod;
  logic             flush_exit;
  logic [W-1:0]     push_pix;

  logic             vld_p0;
  logic             last_p0;
  logic [ROW_W-1:0] row_p0;
  logic [COL_W-1:0] col_p0;
  logic [W-1:0]     win_p0 [K][K];
  logic [K*K*W_COEF-1:0] coef_p0;
  logic [W-1:0]     lbuf [K-1][IMG_WIDTH];

  logic [K-1:0]             row_ok;
  logic [K-1:0]             col_ok;
  logic signed [SUM_W-1:0]  sum_p0;
  logic [W-1:0]             pix_p0;
  logic                     y_last;

  // ---------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------
  function automatic logic signed [PROD_W-1:0] mul_px(
    input logic [W-1:0]              px,
    input logic signed [W_COEF-1:0]  c
  );
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = PROD_W'(signed'({1'b0, px}));
    b = PROD_W'(c);
    return a * b;
  endfunction

  function automatic logic signed [SUM_W-1:0] mag(
    input logic signed [SUM_W-1:0] s
  );
`ifdef STREAM_CONV2D_ABS_EN
    return (s < 0) ? -s : s;
`else
    return s;
`endif
  endfunction

  function automatic logic signed [SUM_W-1:0] round_shift(
    input logic signed [SUM_W-1:0] s
  );
    logic signed [SUM_W-1:0] half;
    // (1 << SHIFT) >> 1 is 2^(SHIFT-1), or 0 when SHIFT is 0.
    half = (SUM_W'(1) << SHIFT) >>> 1;
    return (s + half) >>> SHIFT;
  endfunction

  function automatic logic [W-1:0] sat(
    input logic signed [SUM_W-1:0] v
  );
    if (v < 0)
      return '0;
    else if (v > PIX_MAX)
      return '1;
    else
      return v[W-1:0];
  endfunction

  // ---------------------------------------------------------------------
  // Handshake and push control
  // ---------------------------------------------------------------------
  // The output register can take a new value this cycle.
  assign adv        = !y_valid || y_ready;
  assign x_acc      = x_valid && x_ready;
  assign flush_push = (state == FLUSH) && adv && (push_cnt != CNT_W'(NPUSH));
  assign push       = x_acc || flush_push;
  assign push_pix   = (state == FLUSH) ? '0 : x_data;
  assign out_prod   = push && (push_cnt >= CNT_W'(NLEAD));
  // Leave FLUSH only once the final window has moved into the output
  // register. IDLE can then accept a pixel without disturbing the window.
  assign flush_exit = (state == FLUSH) && (push_cnt == CNT_W'(NPUSH)) &&
                      (!vld_p0 || adv);
  assign frame_done = y_valid && y_ready && y_last;

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (x_acc) state_nxt = FILL;
      FILL:  if (x_acc && (push_cnt == CNT_W'(NLEAD - 1))) state_nxt = RUN;
      RUN:   if (x_acc && (push_cnt == CNT_W'(NPIX - 1)))  state_nxt = FLUSH;
      FLUSH: if (flush_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    x_ready = 1'b0;
    case (state)
      IDLE:      x_ready = rst_n;
      FILL, RUN: x_ready = rst_n && adv;
      default:   x_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_exit) begin
      push_cnt <= '0;
      in_col   <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else if (push) begin
      push_cnt <= push_cnt + 1'b1;
      in_col   <= (in_col == COL_W'(IMG_WIDTH - 1)) ? '0 : in_col + 1'b1;
      if (out_prod) begin
        if (out_col == COL_W'(IMG_WIDTH - 1)) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // p0: line buffers and window register
  // ---------------------------------------------------------------------
  // win_p0[i][j]: row i is top to bottom, column j is left to right.
  // Column K-1 is the newest pushed column. The window holds the last K
  // pushed columns. Near the left and right edges this wraps across a line
  // boundary, but those columns are masked by col_ok.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && x_acc)
      coef_p0 <= kernel;
    if (push) begin
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K - 1; j++)
          win_p0[i][j] <= win_p0[i][j+1];
      for (int i = 0; i < K - 1; i++)
        win_p0[i][K-1] <= lbuf[K-2-i][in_col];
      win_p0[K-1][K-1] <= push_pix;
      lbuf[0][in_col] <= push_pix;
      for (int m = 1; m < K - 1; m++)
        lbuf[m][in_col] <= lbuf[m-1][in_col];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      row_p0  <= '0;
      col_p0  <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
      y_data  <= '0;
    end else begin
      if (push) begin
        vld_p0 <= out_prod;
        if (out_prod) begin
          row_p0  <= out_row;
          col_p0  <= out_col;
          last_p0 <= (out_row == ROW_W'(IMG_HEIGHT - 1)) &&
                     (out_col == COL_W'(IMG_WIDTH - 1));
        end
      end else if (adv) begin
        vld_p0 <= 1'b0;
      end
      // -------------------------------------------------------------------
      // p1: output register
      // -------------------------------------------------------------------
      if (adv) begin
        y_valid <= vld_p0;
        y_last  <= vld_p0 && last_p0;
        if (vld_p0)
          y_data <= pix_p0;
      end
    end
  end

  // Zero padding: mask window taps whose image position is off-image.
  always_comb begin
    row_ok = '0;
    col_ok = '0;
    for (int i = 0; i < K; i++) begin
      row_ok[i] = (int'(row_p0) + i >= R) && (int'(row_p0) + i < IMG_HEIGHT + R);
      col_ok[i] = (int'(col_p0) + i >= R) && (int'(col_p0) + i < IMG_WIDTH + R);
    end
  end

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        if (row_ok[i] && col_ok[j])
          sum_p0 = sum_p0 + SUM_W'(mul_px(win_p0[i][j],
                                          coef_p0[(i*K+j)*W_COEF +: W_COEF]));
  end

  assign pix_p0 = sat(round_shift(mag(sum_p0)));

endmodule

// File: tb/tb_stream_conv2d.sv
`timescale 1ns/1ps
module tb_stream_conv2d;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int KS   = 3;
  localparam int PW   = 8;
  localparam int CW   = 8;
  localparam int NPIX = IW * IH;
  localparam int NCAP = 1024;
`ifdef STREAM_CONV2D_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   x_valid;
  logic [PW-1:0]          x_data;
  logic                   y_ready;
  logic [KS*KS*CW-1:0]    kernel;
  logic                   x_ready0, y_valid0, fd0;
  logic [PW-1:0]          y_data0;
  logic                   x_ready3, y_valid3, fd3;
  logic [PW-1:0]          y_data3;

  stream_conv2d #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .K(KS), .W(PW), .W_COEF(CW), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready0), .x_data(x_data),
    .y_valid(y_valid0), .y_ready(y_ready), .y_data(y_data0),
    .kernel(kernel), .frame_done(fd0)
  );

  stream_conv2d #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .K(KS), .W(PW), .W_COEF(CW), .SHIFT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready3), .x_data(x_data),
    .y_valid(y_valid3), .y_ready(y_ready), .y_data(y_data3),
    .kernel(kernel), .frame_done(fd3)
  );

  // Output capture: a transfer happens at the next rising edge when
  // y_valid && y_ready hold at the falling edge.
  logic [PW-1:0] cap0 [NCAP];
  logic [PW-1:0] cap3 [NCAP];
  int ncap0 = 0;
  int nfd0  = 0;

  always @(negedge clk) begin
    if (y_valid0 && y_ready) begin
      if (ncap0 < NCAP) begin
        cap0[ncap0] <= y_data0;
        cap3[ncap0] <= y_data3;
      end
      ncap0 <= ncap0 + 1;
    end
    if (fd0)
      nfd0 <= nfd0 + 1;
  end

  int img  [NPIX];
  int kern [KS*KS];
  int n_cmp;
  int n_err;
  int fbase;
  int fdbase;
  int cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Direct 2D convolution with zero padding, rounding and clamping.
  function automatic int ref_px(input int r, input int c, input int shift);
    int s;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < IH && c + dc >= 0 && c + dc < IW)
          s += img[(r + dr) * IW + c + dc] * kern[(dr + 1) * KS + dc + 1];
    if (ABS && s < 0) s = -s;
    if (shift > 0) s = (s + (1 << (shift - 1))) >>> shift;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic load_kernel();
    for (int i = 0; i < KS * KS; i++)
      kernel[i*CW +: CW] = kern[i][CW-1:0];
  endtask

  // Streams img as one frame. Valid/ready are raised with the given
  // percentage. kchg_at zeroes the kernel input once that many pixels have
  // been accepted. Also checks that y_data holds while stalled.
  task automatic run_frame(input int rv, input int rr, input int kchg_at);
    int idx;
    logic pv, pr;
    logic [PW-1:0] pd;
    idx = 0; cyc = 0; pv = 1'b0; pr = 1'b1; pd = '0;
    fbase = ncap0; fdbase = nfd0;
    while ((ncap0 - fbase < NPIX) && cyc < 3000) begin
      x_valid = (idx < NPIX) && ($urandom_range(0, 99) < rv);
      x_data  = (idx < NPIX) ? img[idx][PW-1:0] : 8'h5A;
      y_ready = ($urandom_range(0, 99) < rr);
      if (idx == kchg_at) kernel = '0;
      @(negedge clk);
      if (pv && !pr) check("hold", {23'd0, y_valid0, y_data0}, {23'd0, 1'b1, pd});
      pv = y_valid0; pr = y_ready; pd = y_data0;
      if (x_valid && x_ready0) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    check("frame_timeout", {31'd0, cyc < 3000}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("n_out", ncap0 - fbase, NPIX);
    check("n_frame_done", nfd0 - fdbase, 1);
    check("idle_x_ready", {31'd0, x_ready0}, 32'd1);
  endtask

  task automatic compare_frame(input string tag, input bit use3);
    for (int k = 0; k < NPIX; k++) begin
      if (use3)
        check($sformatf("%s_s3[%0d,%0d]", tag, k / IW, k % IW), {24'd0, cap3[fbase + k]}, ref_px(k / IW, k % IW, 3));
      else
        check($sformatf("%s_s0[%0d,%0d]", tag, k / IW, k % IW), {24'd0, cap0[fbase + k]}, ref_px(k / IW, k % IW, 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1; kernel = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_y_valid", {31'd0, y_valid0}, 32'd0);
    check("rst_y_data", {24'd0, y_data0}, 32'd0);
    check("rst_frame_done", {31'd0, fd0}, 32'd0);
    check("rst_x_ready", {31'd0, x_ready0}, 32'd0);
    check("rst_y_valid_s3", {31'd0, y_valid3}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_x_ready", {31'd0, x_ready0}, 32'd1);
    @(posedge clk); #1;

    // Identity kernel on a ramp at full rate; kernel input zeroed mid-frame
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    for (int i = 0; i < NPIX; i++) img[i] = i;
    load_kernel();
    run_frame(100, 100, 10);
    check("throughput_cycles", {31'd0, cyc <= NPIX + 9 + 4}, 32'd1);
    check("ident_first", {24'd0, cap0[fbase]}, 32'd0);
    check("ident_last", {24'd0, cap0[fbase + 47]}, 32'd47);
    compare_frame("ident", 1'b0);
    compare_frame("ident", 1'b1);

    // All-ones kernel, constant 10
    kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < NPIX; i++) img[i] = 10;
    load_kernel();
    run_frame(100, 100, -1);
    check("ones_corner_s3", {24'd0, cap3[fbase + 0]}, 32'd5);
    check("ones_edge_s3", {24'd0, cap3[fbase + 3]}, 32'd8);
    check("ones_interior_s3", {24'd0, cap3[fbase + 2*IW + 3]}, 32'd11);
    check("ones_corner_s0", {24'd0, cap0[fbase + 0]}, 32'd40);
    check("ones_interior_s0", {24'd0, cap0[fbase + 2*IW + 3]}, 32'd90);
    compare_frame("ones", 1'b0);
    compare_frame("ones", 1'b1);

    // Sharpen kernel, constant 200
    kern = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    for (int i = 0; i < NPIX; i++) img[i] = 200;
    load_kernel();
    run_frame(100, 100, -1);
    check("sharp_corner", {24'd0, cap0[fbase + 0]}, 32'd255);
    check("sharp_edge", {24'd0, cap0[fbase + 3]}, 32'd255);
    check("sharp_interior", {24'd0, cap0[fbase + 2*IW + 3]}, 32'd200);
    compare_frame("sharp", 1'b0);

    // Random image: full rate, then 50% valid / 50% ready
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
    load_kernel();
    run_frame(100, 100, -1);
    compare_frame("rnd_clean", 1'b0);
    load_kernel();
    run_frame(50, 50, -1);
    compare_frame("rnd_bp", 1'b0);
    compare_frame("rnd_bp", 1'b1);

    // Reset after 20 inputs of a bright frame, then a full random frame
    for (int i = 0; i < NPIX; i++) img[i] = 255;
    load_kernel();
    for (int i = 0; i < 20; i++) begin
      x_valid = 1'b1;
      x_data  = img[i][PW-1:0];
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_y_valid", {31'd0, y_valid0}, 32'd0);
    check("midrst_x_ready", {31'd0, x_ready0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NPIX; i++) img[i] = int'($urandom_range(0, 255));
    run_frame(100, 100, -1);
    compare_frame("postrst", 1'b0);

    // Edge-detect kernel on a vertical step
    kern = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
    for (int i = 0; i < NPIX; i++) img[i] = ((i % IW) < 4) ? 0 : 100;
    load_kernel();
    run_frame(100, 100, -1);
    check("edge_2_3", {24'd0, cap0[fbase + 2*IW + 3]}, ABS ? 32'd255 : 32'd0);
    check("edge_2_4", {24'd0, cap0[fbase + 2*IW + 4]}, 32'd255);
    compare_frame("edge", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
